// File: rtl/rs_alu.sv
// ALU reservation station with a single-cycle integer ALU feeding the ROB write port.
// Optional macro AGE_SELECT_EN: oldest-first select via an age matrix (default: lowest index).
module rs_alu #(
  parameter int RS_SIZE   = 8,
  parameter int RS_WIDTH  = 3,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  output logic                 rs_full,
  input  logic                 issue_valid,
  input  logic [3:0]           issue_op,
  input  logic [ROB_WIDTH-1:0] issue_rob_id,
  input  logic                 issue_q1_pend,
  input  logic [ROB_WIDTH-1:0] issue_q1,
  input  logic [31:0]          issue_v1,
  input  logic                 issue_q2_pend,
  input  logic [ROB_WIDTH-1:0] issue_q2,
  input  logic [31:0]          issue_v2,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_value,
  output logic                 alu_ready,
  output logic [ROB_WIDTH-1:0] alu_rob_id,
  output logic [31:0]          alu_value
);

  logic [RS_SIZE-1:0]   ent_vld, ent_p1, ent_p2;
  logic [3:0]           ent_op  [RS_SIZE];
  logic [ROB_WIDTH-1:0] ent_rob [RS_SIZE];
  logic [ROB_WIDTH-1:0] ent_q1  [RS_SIZE];
  logic [ROB_WIDTH-1:0] ent_q2  [RS_SIZE];
  logic [31:0]          ent_v1  [RS_SIZE];
  logic [31:0]          ent_v2  [RS_SIZE];

  logic [RS_SIZE-1:0]   elig, sel_oh, free_vec, alloc_oh, wk_p1, wk_p2;
  logic [31:0]          wk_v1 [RS_SIZE];
  logic [31:0]          wk_v2 [RS_SIZE];
  logic                 sel_vld, alloc_found, alloc_ok, iss_p1, iss_p2;
  logic [RS_WIDTH-1:0]  sel_idx, alloc_idx;
  logic [31:0]          iss_v1, iss_v2;

  function automatic logic [31:0] alu_calc(input logic [3:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0]        res;
    sa = a;
    sb = b;
    case (f)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      4'd4:    res = a ^ b;
      4'd5:    res = a << b[4:0];
      4'd6:    res = a >> b[4:0];
      4'd7:    res = sa >>> b[4:0];
      4'd8:    res = {31'd0, sa < sb};
      4'd9:    res = {31'd0, a < b};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Operand snoop: the ALU broadcast has priority over the LSB broadcast.
  function automatic logic [32:0] snoop(input logic pend, input logic [ROB_WIDTH-1:0] tag,
                                        input logic [31:0] val,
                                        input logic a_rdy, input logic [ROB_WIDTH-1:0] a_tag,
                                        input logic [31:0] a_val,
                                        input logic l_rdy, input logic [ROB_WIDTH-1:0] l_tag,
                                        input logic [31:0] l_val);
    logic [32:0] r;
    r = {pend, val};
    if (pend && a_rdy && a_tag == tag)      r = {1'b0, a_val};
    else if (pend && l_rdy && l_tag == tag) r = {1'b0, l_val};
    return r;
  endfunction

  assign rs_full = &ent_vld;
  assign elig    = ent_vld & ~ent_p1 & ~ent_p2;

`ifdef AGE_SELECT_EN
  // age[i][j] = 1 means entry j was issued before entry i.
  logic [RS_SIZE-1:0] age [RS_SIZE];

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!sel_vld && elig[i] && !(|(age[i] & elig))) begin
        sel_vld = 1'b1;
        sel_idx = RS_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
    end else if (rdy_in && !clear) begin
      if (sel_vld) begin
        for (int j = 0; j < RS_SIZE; j++) age[j][sel_idx] <= 1'b0;
        age[sel_idx] <= '0;
      end
      if (alloc_ok) begin
        for (int j = 0; j < RS_SIZE; j++) age[j][alloc_idx] <= 1'b0;
        age[alloc_idx] <= ent_vld & ~sel_oh;
      end
    end
  end
`else
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!sel_vld && elig[i]) begin
        sel_vld = 1'b1;
        sel_idx = RS_WIDTH'(i);
      end
    end
  end
`endif

  // The entry executing this cycle counts as free for a same-cycle issue.
  always_comb begin
    sel_oh      = sel_vld ? (RS_SIZE'(1) << sel_idx) : '0;
    free_vec    = ~ent_vld | sel_oh;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!alloc_found && free_vec[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = RS_WIDTH'(i);
      end
    end
    alloc_ok = issue_valid && !rs_full;
    alloc_oh = alloc_ok ? (RS_SIZE'(1) << alloc_idx) : '0;
    {iss_p1, iss_v1} = snoop(issue_q1_pend, issue_q1, issue_v1, alu_ready, alu_rob_id,
                             alu_value, lsb_ready, lsb_rob_id, lsb_value);
    {iss_p2, iss_v2} = snoop(issue_q2_pend, issue_q2, issue_v2, alu_ready, alu_rob_id,
                             alu_value, lsb_ready, lsb_rob_id, lsb_value);
    for (int i = 0; i < RS_SIZE; i++) begin
      {wk_p1[i], wk_v1[i]} = snoop(ent_p1[i], ent_q1[i], ent_v1[i], alu_ready, alu_rob_id,
                                   alu_value, lsb_ready, lsb_rob_id, lsb_value);
      {wk_p2[i], wk_v2[i]} = snoop(ent_p2[i], ent_q2[i], ent_v2[i], alu_ready, alu_rob_id,
                                   alu_value, lsb_ready, lsb_rob_id, lsb_value);
    end
  end

  // Select/execute -> registered result and station control state
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ent_vld    <= '0;
      ent_p1     <= '0;
      ent_p2     <= '0;
      alu_ready  <= 1'b0;
      alu_rob_id <= '0;
      alu_value  <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        ent_vld    <= '0;
        alu_ready  <= 1'b0;
        alu_rob_id <= '0;
        alu_value  <= '0;
      end else begin
        ent_vld   <= (ent_vld & ~sel_oh) | alloc_oh;
        ent_p1    <= wk_p1;
        ent_p2    <= wk_p2;
        alu_ready <= sel_vld;
        if (sel_vld) begin
          alu_rob_id <= ent_rob[sel_idx];
          alu_value  <= alu_calc(ent_op[sel_idx], ent_v1[sel_idx], ent_v2[sel_idx]);
        end
        if (alloc_ok) begin
          ent_p1[alloc_idx] <= iss_p1;
          ent_p2[alloc_idx] <= iss_p2;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_v1[i] <= wk_v1[i];
        ent_v2[i] <= wk_v2[i];
      end
      if (alloc_ok) begin
        ent_op[alloc_idx]  <= issue_op;
        ent_rob[alloc_idx] <= issue_rob_id;
        ent_q1[alloc_idx]  <= issue_q1;
        ent_q2[alloc_idx]  <= issue_q2;
        ent_v1[alloc_idx]  <= iss_v1;
        ent_v2[alloc_idx]  <= iss_v2;
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed cases plus randomized traffic against a station model.
module tb_rs_alu;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, clear, rs_full;
  logic        issue_valid, issue_q1_pend, issue_q2_pend, lsb_ready;
  logic [3:0]  issue_op, issue_rob_id, issue_q1, issue_q2, lsb_rob_id;
  logic [31:0] issue_v1, issue_v2, lsb_value;
  logic        alu_ready;
  logic [3:0]  alu_rob_id;
  logic [31:0] alu_value;

  int n_chk = 0;
  int n_err = 0;

`ifdef AGE_SELECT_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  rs_alu #(.RS_SIZE(8), .RS_WIDTH(3), .ROB_WIDTH(4)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .rs_full(rs_full),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob_id(issue_rob_id),
    .issue_q1_pend(issue_q1_pend), .issue_q1(issue_q1), .issue_v1(issue_v1),
    .issue_q2_pend(issue_q2_pend), .issue_q2(issue_q2), .issue_v2(issue_v2),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .alu_ready(alu_ready), .alu_rob_id(alu_rob_id), .alu_value(alu_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit [3:0]    op, rob, q1, q2;
    bit          p1, p2;
    bit [31:0]   v1, v2;
    int unsigned seq;
  } ent_t;

  ent_t        m [8];
  bit          m_ready;
  bit [3:0]    m_rob;
  bit [31:0]   m_val;
  int unsigned seq_ctr = 0;

  function automatic bit [31:0] ref_alu(bit [3:0] op, bit [31:0] a, bit [31:0] b);
    bit [31:0] r;
    int sh;
    sh = int'(b[4:0]);
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a << sh;
      6: r = a >> sh;
      7: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      8: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      9: r = {31'd0, a < b};
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 8; i++) if (m[i].v) c++;
    return c;
  endfunction

  task automatic model_flush();
    for (int i = 0; i < 8; i++) m[i].v = 1'b0;
    m_ready = 1'b0;
    m_rob   = 0;
    m_val   = 0;
  endtask

  task automatic model_step();
    bit       a_rdy;
    bit [3:0] a_tag;
    bit [31:0] a_val;
    int       best, k, cnt;
    if (!rst_in) model_flush();
    else if (!rdy_in) ;
    else if (clear) model_flush();
    else begin
      a_rdy = m_ready; a_tag = m_rob; a_val = m_val;
      cnt  = m_count();
      best = -1;
      for (int i = 0; i < 8; i++)
        if (m[i].v && !m[i].p1 && !m[i].p2)
          if (best < 0 || (AGE && m[i].seq < m[best].seq)) best = i;
      if (best >= 0) begin
        m_ready = 1'b1;
        m_rob   = m[best].rob;
        m_val   = ref_alu(m[best].op, m[best].v1, m[best].v2);
        m[best].v = 1'b0;
      end else m_ready = 1'b0;
      for (int i = 0; i < 8; i++) if (m[i].v) begin
        if (m[i].p1 && a_rdy && a_tag == m[i].q1) begin m[i].p1 = 0; m[i].v1 = a_val; end
        else if (m[i].p1 && lsb_ready && lsb_rob_id == m[i].q1) begin m[i].p1 = 0; m[i].v1 = lsb_value; end
        if (m[i].p2 && a_rdy && a_tag == m[i].q2) begin m[i].p2 = 0; m[i].v2 = a_val; end
        else if (m[i].p2 && lsb_ready && lsb_rob_id == m[i].q2) begin m[i].p2 = 0; m[i].v2 = lsb_value; end
      end
      if (issue_valid && cnt < 8) begin
        k = 0;
        while (m[k].v) k++;
        m[k].v = 1; m[k].op = issue_op; m[k].rob = issue_rob_id; m[k].seq = seq_ctr++;
        m[k].q1 = issue_q1; m[k].p1 = issue_q1_pend; m[k].v1 = issue_v1;
        m[k].q2 = issue_q2; m[k].p2 = issue_q2_pend; m[k].v2 = issue_v2;
        if (m[k].p1 && a_rdy && a_tag == issue_q1) begin m[k].p1 = 0; m[k].v1 = a_val; end
        else if (m[k].p1 && lsb_ready && lsb_rob_id == issue_q1) begin m[k].p1 = 0; m[k].v1 = lsb_value; end
        if (m[k].p2 && a_rdy && a_tag == issue_q2) begin m[k].p2 = 0; m[k].v2 = a_val; end
        else if (m[k].p2 && lsb_ready && lsb_rob_id == issue_q2) begin m[k].p2 = 0; m[k].v2 = lsb_value; end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #2;
    chk("rs_full", {31'd0, rs_full}, {31'd0, m_count() == 8});
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, m_ready});
    chk("alu_rob_id", {28'd0, alu_rob_id}, {28'd0, m_rob});
    chk("alu_value", alu_value, m_val);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; lsb_ready = 0; clear = 0;
    issue_q1_pend = 0; issue_q2_pend = 0;
  endtask

  task automatic drive_issue(input logic [3:0] op, input logic [3:0] rob,
                             input logic p1, input logic [3:0] q1, input logic [31:0] v1,
                             input logic p2, input logic [3:0] q2, input logic [31:0] v2);
    issue_valid = 1; issue_op = op; issue_rob_id = rob;
    issue_q1_pend = p1; issue_q1 = q1; issue_v1 = v1;
    issue_q2_pend = p2; issue_q2 = q2; issue_v2 = v2;
  endtask

  task automatic drive_lsb(input logic [3:0] tag, input logic [31:0] val);
    lsb_ready = 1; lsb_rob_id = tag; lsb_value = val;
  endtask

  initial begin
    rst_in = 0; rdy_in = 1; issue_op = 0; issue_rob_id = 0; issue_q1 = 0; issue_q2 = 0;
    issue_v1 = 0; issue_v2 = 0; lsb_rob_id = 0; lsb_value = 0;
    idle();
    tick(); tick();
    chk("reset_ready", {31'd0, alu_ready}, 32'd0);
    chk("reset_full", {31'd0, rs_full}, 32'd0);
    rst_in = 1;

    // ADD 5+7
    drive_issue(4'd0, 4'd3, 0, 0, 32'd5, 0, 0, 32'd7); tick(); idle(); tick();
    chk("add_ready", {31'd0, alu_ready}, 32'd1);
    chk("add_rob", {28'd0, alu_rob_id}, 32'd3);
    chk("add_value", alu_value, 32'd12);
    tick();
    chk("add_pulse", {31'd0, alu_ready}, 32'd0);

    // SUB woken by LSB
    drive_issue(4'd1, 4'd1, 1, 4'd6, 32'd0, 0, 0, 32'd1); tick(); idle(); tick();
    drive_lsb(4'd6, 32'd0); tick(); idle(); tick();
    chk("sub_rob", {28'd0, alu_rob_id}, 32'd1);
    chk("sub_value", alu_value, 32'hFFFF_FFFF);

    // Fill the station, 9th refused, then drain back-to-back
    for (int i = 0; i < 8; i++) begin
      drive_issue(4'd0, 4'(i), 1, 4'd9, 32'd0, 0, 0, 32'(i)); tick();
    end
    idle();
    chk("full_set", {31'd0, rs_full}, 32'd1);
    drive_issue(4'd0, 4'd8, 0, 0, 32'd1, 0, 0, 32'd1); tick(); idle();
    chk("full_hold", {31'd0, rs_full}, 32'd1);
    drive_lsb(4'd9, 32'd100); tick(); idle();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_ready", {31'd0, alu_ready}, 32'd1);
      chk("drain_rob", {28'd0, alu_rob_id}, 32'(i));
      chk("drain_value", alu_value, 32'(100 + i));
    end

    // Issue bypass from the same-cycle ALU broadcast
    drive_issue(4'd0, 4'd2, 0, 0, 32'd1, 0, 0, 32'd1); tick(); idle(); tick();
    chk("byp_src", {28'd0, alu_rob_id}, 32'd2);
    drive_issue(4'd1, 4'd4, 1, 4'd2, 32'd0, 0, 0, 32'd5); tick(); idle(); tick();
    chk("byp_ready", {31'd0, alu_ready}, 32'd1);
    chk("byp_value", alu_value, 32'hFFFF_FFFD);

    // Issue during clear
    drive_issue(4'd0, 4'd7, 0, 0, 32'd3, 0, 0, 32'd3); clear = 1; tick(); idle();
    chk("clr_ready", {31'd0, alu_ready}, 32'd0);
    tick();
    chk("clr_noentry", {31'd0, alu_ready}, 32'd0);

    // Pause with a result out and another entry eligible
    drive_issue(4'd0, 4'd5, 0, 0, 32'd10, 0, 0, 32'd20); tick();
    drive_issue(4'd3, 4'd6, 0, 0, 32'hF0, 0, 0, 32'h0F); tick(); idle();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_rob", {28'd0, alu_rob_id}, 32'd5);
      chk("pause_value", alu_value, 32'd30);
    end
    rdy_in = 1; tick();
    chk("resume_rob", {28'd0, alu_rob_id}, 32'd6);
    chk("resume_value", alu_value, 32'hFF);

    // Reset mid-run
    for (int i = 0; i < 3; i++) begin
      drive_issue(4'd0, 4'(i), 1, 4'd15, 0, 0, 0, 0); tick();
    end
    drive_issue(4'd0, 4'd6, 0, 0, 32'd1, 0, 0, 32'd1); tick(); idle();
    rst_in = 0; tick(); rst_in = 1;
    chk("rst_full", {31'd0, rs_full}, 32'd0);
    chk("rst_ready", {31'd0, alu_ready}, 32'd0);
    chk("rst_value", alu_value, 32'd0);
    drive_lsb(4'd15, 32'd1); tick(); idle(); tick(); tick();
    chk("rst_gone", {31'd0, alu_ready}, 32'd0);

    // SLTU / SLT
    drive_issue(4'd9, 4'd3, 0, 0, 32'd1, 0, 0, 32'hFFFF_FFFF); tick();
    drive_issue(4'd8, 4'd4, 0, 0, 32'd1, 0, 0, 32'hFFFF_FFFF); tick(); idle();
    chk("sltu", alu_value, 32'd1);
    tick();
    chk("slt", alu_value, 32'd0);
    tick();

    // Select order: rob 5 in entry 4 (older), rob 2 in entry 0 (younger)
    for (int i = 0; i < 4; i++) begin
      drive_issue(4'd0, 4'(i), 1, 4'd11, 0, 0, 0, 0); tick();
    end
    drive_issue(4'd7, 4'd5, 1, 4'd12, 0, 0, 0, 32'd4); tick(); idle();
    drive_lsb(4'd11, 32'd0); tick(); idle();
    for (int i = 0; i < 6; i++) tick();
    drive_issue(4'd0, 4'd2, 1, 4'd12, 0, 0, 0, 32'd1); tick(); idle();
    drive_lsb(4'd12, 32'h8000_0000); tick(); idle(); tick();
    chk("order_first", {28'd0, alu_rob_id}, AGE ? 32'd5 : 32'd2);
    chk("order_first_val", alu_value, AGE ? 32'hF800_0000 : 32'h8000_0001);
    tick();
    chk("order_second", {28'd0, alu_rob_id}, AGE ? 32'd2 : 32'd5);
    chk("order_second_val", alu_value, AGE ? 32'h8000_0001 : 32'hF800_0000);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_in        = ($urandom_range(0, 299) != 0);
      rdy_in        = ($urandom_range(0, 9) != 0);
      clear         = ($urandom_range(0, 59) == 0);
      issue_valid   = ($urandom_range(0, 9) < 6);
      issue_op      = 4'($urandom_range(0, 15));
      issue_rob_id  = 4'($urandom);
      issue_q1_pend = 1'($urandom);
      issue_q1      = 4'($urandom);
      issue_v1      = $urandom;
      issue_q2_pend = 1'($urandom);
      issue_q2      = 4'($urandom);
      issue_v2      = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
      lsb_ready     = ($urandom_range(0, 2) == 0);
      lsb_rob_id    = 4'($urandom);
      if (m_ready && lsb_rob_id == m_rob) lsb_rob_id = m_rob + 4'd1;
      lsb_value     = $urandom;
      tick();
    end
    idle(); rst_in = 1; rdy_in = 1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
